// File: rtl/reg_file_sb.sv
// Decode-stage register file: two async read ports, one sync write port,
// optional write bypass, pending-write scoreboard and a clear sequencer.
module reg_file_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int BYPASS        = 1,
    parameter int TAP_ADDR      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic                     WE3,
    input  logic                     RSV,
    input  logic [ADDRESS_WIDTH-1:0] RSV_AD,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic                     BUSY1,
    output logic                     BUSY2,
    output logic [DATA_WIDTH-1:0]    TAP,
    output logic                     ready
);
    localparam int N = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = ADDRESS_WIDTH'(N - 1);
    localparam logic [ADDRESS_WIDTH-1:0] TAP_IDX  = ADDRESS_WIDTH'(TAP_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_AD  = '0;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    regs_q [N];
    logic [DATA_WIDTH-1:0]    regs_d [N];
    logic [N-1:0]             pend_q, pend_d;

    logic run;
    logic hit1, hit2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        if (rst) begin
            state_d = CLEAR;
            cnt_d   = '0;
            pend_d  = '0;
        end else if (state_q == CLEAR) begin
            regs_d[cnt_q] = '0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = RUN;
        end else begin
            if (WE3 && AD3 != ZERO_AD) begin
                regs_d[AD3] = WD3;
                pend_d[AD3] = 1'b0;
            end
            // Applied after the write so a same-edge reservation wins.
            if (RSV && RSV_AD != ZERO_AD) pend_d[RSV_AD] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        regs_q  <= regs_d;
        pend_q  <= pend_d;
    end

    assign run  = (state_q == RUN);
    assign hit1 = (BYPASS != 0) && WE3 && (AD3 == AD1);
    assign hit2 = (BYPASS != 0) && WE3 && (AD3 == AD2);

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (run && AD1 != ZERO_AD) RD1 = hit1 ? WD3 : regs_q[AD1];
        if (run && AD2 != ZERO_AD) RD2 = hit2 ? WD3 : regs_q[AD2];
    end

    assign BUSY1 = run && pend_q[AD1] && !hit1;
    assign BUSY2 = run && pend_q[AD2] && !hit2;
    assign TAP   = run ? regs_q[TAP_IDX] : '0;
    assign ready = run;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass instances share stimulus,
// checked against an array-based model plus a directed vector table.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst, we3, rsv;
    logic [4:0]  ad1, ad2, ad3, rsv_ad;
    logic [31:0] wd3;

    logic [31:0] rd1_b, rd2_b, tap_b, rd1_n, rd2_n, tap_n;
    logic        b1_b, b2_b, rdy_b, b1_n, b2_n, rdy_n;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_clear;
    int          m_cnt;

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1)) u_bp (
        .clk(clk), .rst(rst), .AD1(ad1), .AD2(ad2), .AD3(ad3),
        .WD3(wd3), .WE3(we3), .RSV(rsv), .RSV_AD(rsv_ad),
        .RD1(rd1_b), .RD2(rd2_b), .BUSY1(b1_b), .BUSY2(b2_b),
        .TAP(tap_b), .ready(rdy_b)
    );

    reg_file_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .AD1(ad1), .AD2(ad2), .AD3(ad3),
        .WD3(wd3), .WE3(we3), .RSV(rsv), .RSV_AD(rsv_ad),
        .RD1(rd1_n), .RD2(rd2_n), .BUSY1(b1_n), .BUSY2(b2_n),
        .TAP(tap_n), .ready(rdy_n)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] e_rd(input bit bp, input logic [4:0] a);
        if (m_clear || a == 5'd0) return 32'd0;
        if (bp && we3 && ad3 == a) return wd3;
        return m_regs[a];
    endfunction

    function automatic logic e_busy(input bit bp, input logic [4:0] a);
        if (m_clear) return 1'b0;
        return m_pend[a] && !(bp && we3 && ad3 == a);
    endfunction

    task automatic check_all();
        chk("bp.rd1", rd1_b, e_rd(1, ad1));
        chk("bp.rd2", rd2_b, e_rd(1, ad2));
        chk("bp.busy1", {31'd0, b1_b}, {31'd0, e_busy(1, ad1)});
        chk("bp.busy2", {31'd0, b2_b}, {31'd0, e_busy(1, ad2)});
        chk("bp.tap", tap_b, m_clear ? 32'd0 : m_regs[10]);
        chk("bp.ready", {31'd0, rdy_b}, {31'd0, !m_clear});
        chk("nb.rd1", rd1_n, e_rd(0, ad1));
        chk("nb.rd2", rd2_n, e_rd(0, ad2));
        chk("nb.busy1", {31'd0, b1_n}, {31'd0, e_busy(0, ad1)});
        chk("nb.busy2", {31'd0, b2_n}, {31'd0, e_busy(0, ad2)});
        chk("nb.tap", tap_n, m_clear ? 32'd0 : m_regs[10]);
        chk("nb.ready", {31'd0, rdy_n}, {31'd0, !m_clear});
    endtask

    task automatic model_edge();
        if (rst) begin
            m_clear = 1;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (m_clear) begin
            m_regs[m_cnt] = 32'd0;
            if (m_cnt == 31) m_clear = 0;
            m_cnt++;
        end else begin
            if (we3 && ad3 != 0) begin
                m_regs[ad3] = wd3;
                m_pend[ad3] = 0;
            end
            if (rsv && rsv_ad != 0) m_pend[rsv_ad] = 1;
        end
    endtask

    task automatic drive(input bit r, input bit we, input logic [4:0] a3,
                         input logic [31:0] wd, input bit rs,
                         input logic [4:0] ra, input logic [4:0] a1,
                         input logic [4:0] a2);
        rst = r; we3 = we; ad3 = a3; wd3 = wd;
        rsv = rs; rsv_ad = ra; ad1 = a1; ad2 = a2;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input bit r);
        drive(r, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!rdy_b && n < 100) begin
            idle(0);
            n++;
        end
        chk(nm, n, 32);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        rs;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] rd1_b;
        logic [31:0] rd1_n;
        logic        b1_b;
        logic        b1_n;
        logic [31:0] rd2_b;
        logic [31:0] tap;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0,  32'h1234, 0, 0, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[2]  = '{1, 10, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0,  0, 0, 0, 10, 0, 32'h55, 32'h55, 0, 0, 0, 32'h55};
        tbl[4]  = '{1, 7,  32'hA5A5A5A5, 0, 0, 7, 0, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h55};
        tbl[5]  = '{0, 0,  0, 0, 0, 7, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 32'h55};
        tbl[6]  = '{0, 0,  0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 32'h55};
        tbl[7]  = '{1, 3,  32'h33, 0, 0, 3, 0, 32'h33, 0, 0, 1, 0, 32'h55};
        tbl[8]  = '{0, 0,  0, 0, 0, 3, 0, 32'h33, 32'h33, 0, 0, 0, 32'h55};
        tbl[9]  = '{0, 0,  0, 1, 4, 4, 0, 0, 0, 0, 0, 0, 32'h55};
        tbl[10] = '{1, 4,  32'h44, 1, 4, 4, 0, 32'h44, 0, 0, 1, 0, 32'h55};
        tbl[11] = '{0, 0,  0, 0, 0, 4, 0, 32'h44, 32'h44, 1, 1, 0, 32'h55};
        tbl[12] = '{1, 4,  32'h45, 0, 0, 4, 4, 32'h45, 32'h44, 0, 1, 32'h45, 32'h55};
        tbl[13] = '{0, 0,  0, 0, 0, 4, 0, 32'h45, 32'h45, 0, 0, 0, 32'h55};

        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        m_clear = 1;
        m_cnt = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_edge();
        #1;
        chk("rst.rd1", rd1_b, 0);
        chk("rst.tap", tap_b, 0);
        chk("rst.busy", {30'd0, b1_b, b2_b}, 0);
        chk("rst.ready", {31'd0, rdy_b}, 0);
        idle(1);
        wait_ready("clear.len");

        for (int i = 0; i < 14; i++) begin
            drive(0, tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].rs,
                  tbl[i].ra, tbl[i].a1, tbl[i].a2);
            #2;
            chk($sformatf("tbl%0d.rd1_b", i), rd1_b, tbl[i].rd1_b);
            chk($sformatf("tbl%0d.rd1_n", i), rd1_n, tbl[i].rd1_n);
            chk($sformatf("tbl%0d.busy_b", i), {31'd0, b1_b}, {31'd0, tbl[i].b1_b});
            chk($sformatf("tbl%0d.busy_n", i), {31'd0, b1_n}, {31'd0, tbl[i].b1_n});
            chk($sformatf("tbl%0d.rd2_b", i), rd2_b, tbl[i].rd2_b);
            chk($sformatf("tbl%0d.tap", i), tap_b, tbl[i].tap);
            tick();
        end

        // Preload, then a single reset pulse must zero everything.
        for (int i = 1; i < 32; i++) begin
            drive(0, 1, 5'(i), $urandom | 32'h1, 1, 5'(i), 0, 0);
            tick();
        end
        idle(1);
        wait_ready("clear2.len");
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            #2;
            chk("clear2.zero", rd1_b | rd2_b, 0);
            tick();
        end

        // Reset again partway through the clear sequence.
        idle(1);
        for (int i = 0; i < 10; i++) idle(0);
        idle(1);
        wait_ready("midclr.len");

        // Writes and reservations during CLEAR must be ignored.
        idle(1);
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, (i % 2) ? 5'd2 : 5'd30, 32'hFFFF0000 + i,
                  1, (i % 2) ? 5'd30 : 5'd2, 5'd2, 5'd30);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 5'd2, 5'd30);
        #2;
        chk("gate.ready", {31'd0, rdy_b}, 1);
        chk("gate.rd", rd1_b | rd2_b | rd1_n | rd2_n, 0);
        chk("gate.busy", {28'd0, b1_b, b2_b, b1_n, b2_n}, 0);
        tick();

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 249) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom));
            if ($urandom_range(0, 3) == 0) ad3 = 5'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the core's single-cycle register file, built for the pipelined core. It provides two combinational read ports, one synchronous write port, optional write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a reset-driven clear sequencer that zeroes every register, one per cycle. It sits in the decode stage: reads and reservations come from decode, and writes come from writeback.

## Interface
- ADDRESS_WIDTH, 5: register address width; the file holds 2**ADDRESS_WIDTH registers.
- DATA_WIDTH, 32: register width.
- BYPASS, 1: 1 routes same-cycle write data to the read ports; 0 disables routing.
- TAP_ADDR, 10: register index driven on TAP, for testbenches.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- AD1  in  ADDRESS_WIDTH  read address 1 (rs1).
- AD2  in  ADDRESS_WIDTH  read address 2 (rs2).
- AD3  in  ADDRESS_WIDTH  write address (rd).
- WD3  in  DATA_WIDTH  write data.
- WE3  in  1  write enable.
- RSV  in  1  reserve enable: marks RSV_AD as pending a write.
- RSV_AD  in  ADDRESS_WIDTH  register to reserve.
- RD1  out  DATA_WIDTH  read data 1.
- RD2  out  DATA_WIDTH  read data 2.
- BUSY1  out  1  AD1 is pending and its data is not available this cycle.
- BUSY2  out  1  AD2 is pending and its data is not available this cycle.
- TAP  out  DATA_WIDTH  contents of register TAP_ADDR.
- ready  out  1  clear sequence complete; normal operation.

## Operation
- Two states, CLEAR and RUN, with a clear counter cnt of width ADDRESS_WIDTH.
- rst=1 at an edge:
  - state <= CLEAR, cnt <= 0.
  - All pending bits <= 0.
  - Applies regardless of current state, so a reset mid-clear restarts from cnt=0.
- CLEAR, rst=0, each edge:
  - Write 0 to register cnt, then cnt <= cnt+1.
  - When cnt = 2**ADDRESS_WIDTH-1, state <= RUN.
- CLEAR outputs and inputs:
  - WE3 and RSV are ignored.
  - RD1, RD2 and TAP are forced to 0; BUSY1, BUSY2 = 0; ready = 0.
- RUN:
  - ready = 1.
  - WE3=1 and AD3≠0: register AD3 <= WD3 and pending[AD3] <= 0.
  - RSV=1 and RSV_AD≠0: pending[RSV_AD] <= 1.
  - Same edge, RSV_AD = AD3 with both enables active: the reservation wins, so the pending bit ends at 1 and the register still takes WD3.
- Register 0:
  - Reads always return 0.
  - Writes and reservations to it are dropped.
  - pending[0] is always 0.
- Reads in RUN (combinational; n = 1, 2):
  - ADn = 0 -> RDn = 0.
  - Else BYPASS=1, WE3=1 and AD3 = ADn -> RDn = WD3.
  - Otherwise RDn = register ADn.
- BUSY in RUN:
  - BUSYn = pending[ADn] AND NOT (BYPASS and WE3 and AD3 = ADn).
  - With BYPASS=0, BUSYn = pending[ADn].
  - A reservation made this cycle is not visible on BUSYn until the next cycle.
- TAP: register TAP_ADDR with no bypass; 0 while in CLEAR.
- All widths are exact: no sign or zero extension, and address comparisons use the full ADDRESS_WIDTH.

## Timing
- Reset values of every output: RD1 = RD2 = TAP = 0, BUSY1 = BUSY2 = 0, ready = 0.
- Clear duration:
  - ready rises after the 2**ADDRESS_WIDTH-th rising edge with rst=0 following reset.
  - With defaults, that is the 32nd edge.
  - Holding rst=1 keeps the block in CLEAR with cnt=0.
- Write latency:
  - Data is visible in storage one edge after WE3.
  - With BYPASS=1, it is visible on RDn in the same cycle.
- Reservation latency: one edge from RSV to BUSYn=1.
- Pending clear: BUSYn drops in the same cycle as the matching write when BYPASS=1, and one edge later when BYPASS=0.
- No read-port stalls: reads are purely combinational from storage, the bypass path and address.

## Test plan
- Clear sequence:
  - Preload registers with nonzero data.
  - Pulse rst for 1 cycle.
  - Required: ready=0 for 32 edges, then 1; every register reads 0.
  - Pulse rst again at cnt=10: ready does not rise until 32 edges after that reset.
- Write/read and x0:
  - Write 0xDEADBEEF to x5, then read AD1=5 -> 0xDEADBEEF.
  - Write 0x1234 to x0, then read AD2=0 -> 0.
  - Write 0x55 to x10: TAP = 0x55 one cycle later.
- Bypass:
  - BYPASS=1, WE3=1, AD3=7, WD3=0xA5A5A5A5, AD1=7: RD1 = 0xA5A5A5A5 in the same cycle.
  - Repeat with BYPASS=0: RD1 holds the old value until the next cycle.
- Scoreboard:
  - RSV x3: BUSY1=1 for AD1=3 from the next cycle.
  - Write x3 with BYPASS=1: BUSY1=0 in that cycle and RD1 = WD3.
  - Next cycle: BUSY1=0.
- Simultaneous reserve and write:
  - With x4 pending, RSV_AD=4 and AD3=4 in the same cycle.
  - Required: x4 = WD3 and pending stays 1, so BUSY for x4 = 1 on the following cycle.
- CLEAR gating:
  - Assert WE3 and RSV during CLEAR.
  - Required: after ready, the targeted registers read 0 and BUSY=0.
